// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the dff_bank_arbiter: FSM encoding and the
// round-robin winner search used by the arbiter.
package dff_bank_arbiter_pkg;

  localparam int STATE_W = 2;
  localparam int RR_MAX  = 8;   // widest supported requester vector
  localparam int CNT_W   = 4;   // flush counter width (FLUSH_CYCLES <= 15)

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // Search req starting at (last+1) mod nreq upward with wrap; first hit wins.
  function automatic rr_pick_t rr_search(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        last,
                                         input int                nreq);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int i = 1; i <= RR_MAX; i++) begin
      cand = (int'(last) + i) % nreq;
      if (!pick.valid && (i <= nreq) && req[cand[2:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = cand[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_reg.sv
// WIDTH-bit D flip-flop bank with asynchronous active-high clear and a
// synchronous write enable.
module dff_bank_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold unless the write enable loads a new word.
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // Storage flops; clear wins over any write.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter and sequencer for one shared flop bank.
// Handshake: a requester raises req[i] with its word on wdata and holds both
// until it sees gnt[i]; the word is captured on the edge that ends the grant
// cycle if req[i] is still high, otherwise the grant is treated as aborted.
// A flush (pulse or level) clears the bank for FLUSH_CYCLES cycles and takes
// priority over writes when both are seen in IDLE.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int FLUSH_CYCLES = 2,
  localparam int OW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  flush_req,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      q,
  output logic                  bank_clr,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  flush_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [OW-1:0]    OWN_RST  = OW'(NREQ - 1);

  state_t            state_q,      state_d;
  logic [NREQ-1:0]   gnt_q,        gnt_d;
  logic [OW-1:0]     owner_q,      owner_d;
  logic [OW-1:0]     prev_owner_q, prev_owner_d;
  logic              pend_q,       pend_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              bank_clr_q,   bank_clr_d;
  logic              busy_q,       busy_d;
  logic              wr_done_q,    wr_done_d;
  logic              flush_done_q, flush_done_d;

  logic [RR_MAX-1:0] req_ext;
  logic [2:0]        owner_ext;
  rr_pick_t          pick;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_word;

  // Widen request vector and owner to the package search width.
  always_comb begin
    req_ext              = '0;
    req_ext[NREQ-1:0]    = req;
    owner_ext            = '0;
    owner_ext[OW-1:0]    = owner_q;
    pick                 = rr_search(req_ext, owner_ext, NREQ);
  end

  // The write lands only if the grantee still requests at the end of GRANT.
  always_comb begin
    wr_en   = (state_q == GRANT) && req[owner_q];
    wr_word = wdata[int'(owner_q)*WIDTH +: WIDTH];
  end

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    prev_owner_d = prev_owner_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req || pend_q) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (pick.valid) begin
          state_d               = GRANT;
          gnt_d                 = '0;
          gnt_d[pick.idx[OW-1:0]] = 1'b1;
          prev_owner_d          = owner_q;
          owner_d               = pick.idx[OW-1:0];
        end
      end
      GRANT: begin
        gnt_d = '0;
        if (flush_req) pend_d = 1'b1;
        if (req[owner_q]) begin
          state_d = DONE;
        end else begin
          // Abort: pointer goes back so the aborted grant costs no turn.
          state_d = IDLE;
          owner_d = prev_owner_q;
        end
      end
      DONE: begin
        if (flush_req) pend_d = 1'b1;
        state_d = IDLE;
      end
      FLUSH: begin
        // flush_req seen here is absorbed, not queued.
        pend_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    bank_clr_d   = (state_d == FLUSH);
    busy_d       = (state_d != IDLE);
    wr_done_d    = (state_d == DONE);
    flush_done_d = (state_d == FLUSH) && (cnt_d == LAST_CNT);
  end

  // State and registered outputs; reset aborts everything at once.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= OWN_RST;
      prev_owner_q <= OWN_RST;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      bank_clr_q   <= 1'b0;
      busy_q       <= 1'b0;
      wr_done_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      prev_owner_q <= prev_owner_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      bank_clr_q   <= bank_clr_d;
      busy_q       <= busy_d;
      wr_done_q    <= wr_done_d;
      flush_done_q <= flush_done_d;
    end
  end

  dff_bank_reg #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .clr (clear | bank_clr_q),
    .en  (wr_en),
    .d   (wr_word),
    .q   (q)
  );

  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign bank_clr   = bank_clr_q;
  assign busy       = busy_q;
  assign wr_done    = wr_done_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed stimulus pushes expected grants,
// written words and flush completions; a negedge monitor pops and compares.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  clear;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  flush_req;
  logic [NREQ-1:0]       gnt;
  logic [1:0]            owner;
  logic [WIDTH-1:0]      q;
  logic                  bank_clr;
  logic                  busy;
  logic                  wr_done;
  logic                  flush_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [NREQ-1:0]  exp_gnt_q[$];
  logic             exp_flush_q[$];

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .clear      (clear),
    .req        (req),
    .wdata      (wdata),
    .flush_req  (flush_req),
    .gnt        (gnt),
    .owner      (owner),
    .q          (q),
    .bank_clr   (bank_clr),
    .busy       (busy),
    .wr_done    (wr_done),
    .flush_done (flush_done)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input int i, input logic [WIDTH-1:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_write(input int i, input logic [WIDTH-1:0] v);
    req = '0;
    req[i] = 1'b1;
    set_wdata(i, v);
    exp_gnt_q.push_back(4'(1 << i));
    exp_q.push_back(v);
    step();
    step();
    req = '0;
    step();
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!clear) begin
      check("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv_done_excl", 32'(wr_done & flush_done), 32'd0);
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
        else check("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (wr_done) begin
        if (exp_q.size() == 0) check("wr_unexpected", 32'(wr_done), 32'd0);
        else check("wr_data", 32'(q), 32'(exp_q.pop_front()));
      end
      if (flush_done) begin
        if (exp_flush_q.size() == 0) check("flush_unexpected", 32'(flush_done), 32'd0);
        else check("flush_done_seen", 32'(flush_done), 32'(exp_flush_q.pop_front()));
      end
    end
  end

  // Stimulus
  initial begin
    clear     = 1'b1;
    req       = '0;
    wdata     = '0;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_owner", 32'(owner), 32'd3);
    check("rst_flags", 32'({bank_clr, busy, wr_done, flush_done}), 32'd0);
    clear = 1'b0;

    // 1: reset in the middle of a grant
    req = 4'b0001;
    set_wdata(0, 8'h3C);
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    #1 clear = 1'b1;
    #1;
    check("t1_async_gnt", 32'(gnt), 32'd0);
    check("t1_async_q", 32'(q), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    step();
    req = '0;
    clear = 1'b0;
    step();
    check("t1_q_after", 32'(q), 32'd0);
    check("t1_owner", 32'(owner), 32'd3);

    // 2: single write, latency and busy span
    req = 4'b0010;
    set_wdata(1, 8'hA5);
    exp_gnt_q.push_back(4'b0010);
    exp_q.push_back(8'hA5);
    step();
    check("t2_gnt", 32'(gnt), 32'h2);
    check("t2_busy0", 32'(busy), 32'd1);
    check("t2_q_early", 32'(q), 32'd0);
    step();
    check("t2_gnt_drop", 32'(gnt), 32'd0);
    check("t2_q", 32'(q), 32'hA5);
    check("t2_wr_done", 32'(wr_done), 32'd1);
    check("t2_owner", 32'(owner), 32'd1);
    check("t2_busy1", 32'(busy), 32'd1);
    req = '0;
    step();
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_wr_done_end", 32'(wr_done), 32'd0);

    // 3: fairness from a fresh reset with all requesters active
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    for (int i = 0; i < NREQ; i++) set_wdata(i, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) begin
      exp_gnt_q.push_back(4'(1 << (i % 4)));
      exp_q.push_back(8'(8'h10 + (i % 4)));
    end
    req = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      step();
      check("t3_spacing", 32'(gnt != '0), 32'(i % 3 == 0));
    end
    req = '0;
    step();
    check("t3_owner", 32'(owner), 32'd0);
    check("t3_q", 32'(q), 32'h10);

    // 4: flush beats a same-edge request; flush_req held into FLUSH is absorbed
    do_write(1, 8'hA5);
    check("t4_q_pre", 32'(q), 32'hA5);
    flush_req = 1'b1;
    req = 4'b0100;
    set_wdata(2, 8'h5A);
    exp_flush_q.push_back(1'b1);
    exp_gnt_q.push_back(4'b0100);
    exp_q.push_back(8'h5A);
    step();
    check("t4_clr0", 32'(bank_clr), 32'd1);
    check("t4_q_zero", 32'(q), 32'd0);
    check("t4_fd0", 32'(flush_done), 32'd0);
    check("t4_gnt_blocked", 32'(gnt), 32'd0);
    step();
    check("t4_clr1", 32'(bank_clr), 32'd1);
    check("t4_fd1", 32'(flush_done), 32'd1);
    flush_req = 1'b0;
    step();
    check("t4_clr_end", 32'(bank_clr), 32'd0);
    check("t4_fd_end", 32'(flush_done), 32'd0);
    step();
    check("t4_gnt2", 32'(gnt), 32'h4);
    step();
    check("t4_q_new", 32'(q), 32'h5A);
    req = '0;
    step();

    // 5: aborted grant restores the pointer
    do_write(0, 8'h3C);
    req = 4'b0100;
    exp_gnt_q.push_back(4'b0100);
    step();
    check("t5_gnt", 32'(gnt), 32'h4);
    check("t5_owner_g", 32'(owner), 32'd2);
    req = '0;
    step();
    check("t5_gnt_drop", 32'(gnt), 32'd0);
    check("t5_no_wr", 32'(wr_done), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_q_keep", 32'(q), 32'h3C);
    check("t5_owner_rest", 32'(owner), 32'd0);
    req = 4'b0110;
    set_wdata(1, 8'h77);
    exp_gnt_q.push_back(4'b0010);
    exp_q.push_back(8'h77);
    step();
    check("t5_gnt1", 32'(gnt), 32'h2);
    step();
    check("t5_q", 32'(q), 32'h77);
    req = '0;
    step();

    // 6: flush pulse during a grant is served after the write
    req = 4'b0001;
    set_wdata(0, 8'hFF);
    exp_gnt_q.push_back(4'b0001);
    exp_q.push_back(8'hFF);
    exp_flush_q.push_back(1'b1);
    step();
    check("t6_gnt", 32'(gnt), 32'h1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    req = '0;
    check("t6_q", 32'(q), 32'hFF);
    check("t6_wr_done", 32'(wr_done), 32'd1);
    check("t6_clr_wait", 32'(bank_clr), 32'd0);
    step();
    check("t6_idle", 32'(busy), 32'd0);
    step();
    check("t6_clr", 32'(bank_clr), 32'd1);
    check("t6_q_zero", 32'(q), 32'd0);
    step();
    check("t6_fd", 32'(flush_done), 32'd1);
    step();
    check("t6_busy_end", 32'(busy), 32'd0);
    repeat (2) step();

    @(negedge clk);
    #1;
    check("sb_q_empty", 32'(exp_q.size()), 32'd0);
    check("sb_gnt_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("sb_flush_empty", 32'(exp_flush_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
